// File: rtl/argmax_row_engine_pkg.sv
`default_nettype none
// ============================================================================
// Package : argmax_pkg
// Brief   : shared state encoding and compare helpers for the argmax engine
// Rev     : 1.0
// ============================================================================
package argmax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Operands are pre-extended to this width so one helper serves every DATA_W up to 64.
    localparam int CMP_W = 65;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic gt_fn(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             signed_cmp
    );
        if (signed_cmp) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // lo carries the lower column index; returns 1 when the higher-index candidate wins.
    function automatic logic take_hi_fn(
        input logic [CMP_W-1:0] lo,
        input logic [CMP_W-1:0] hi,
        input logic             signed_cmp,
        input logic             tie_high
    );
        return gt_fn(hi, lo, signed_cmp) || (tie_high && (hi == lo));
    endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_row_engine_cmp_tree.sv
`default_nettype none
// ============================================================================
// Module : argmax_cmp_tree
// Brief  : combinational max/argmax reduction over one row of NUM_COLS elements
// Rev    : 1.0
// ============================================================================
module argmax_cmp_tree
    import argmax_pkg::*;
#(
    parameter int NUM_COLS   = 3,
    parameter int DATA_W     = 16,
    parameter int SIGNED_CMP = 0,
    parameter int TIE_HIGH   = 0,
    localparam int IDX_W     = clog2_min1(NUM_COLS)
) (
    input  logic [NUM_COLS*DATA_W-1:0] i_vec,
    output logic [IDX_W-1:0]           o_max_idx,
    output logic [DATA_W-1:0]          o_max_val
);

    localparam int LEVELS = IDX_W;

    function automatic logic [CMP_W-1:0] ext_fn(input logic [DATA_W-1:0] v);
        return (SIGNED_CMP != 0) ? {{(CMP_W-DATA_W){v[DATA_W-1]}}, v}
                                 : {{(CMP_W-DATA_W){1'b0}}, v};
    endfunction

    // Level LEVELS holds the leaves (padded to a power of two); level 0 is the root.
    // The left child always covers lower column indices, which makes the tie rule hold globally.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        for (genvar n = 0; n < (1 << l); n++) begin : g_node
            logic [DATA_W-1:0] w_val;
            logic [IDX_W-1:0]  w_idx;
            logic              w_vld;

            if (l == LEVELS) begin : g_leaf
                if (n < NUM_COLS) begin : g_col
                    assign w_val = i_vec[n*DATA_W +: DATA_W];
                    assign w_vld = 1'b1;
                end else begin : g_pad
                    assign w_val = '0;
                    assign w_vld = 1'b0;
                end
                assign w_idx = IDX_W'(n);
            end else begin : g_cmp
                logic w_take_hi;

                assign w_take_hi = g_lvl[l+1].g_node[2*n+1].w_vld &&
                                   (!g_lvl[l+1].g_node[2*n].w_vld ||
                                    take_hi_fn(ext_fn(g_lvl[l+1].g_node[2*n].w_val),
                                               ext_fn(g_lvl[l+1].g_node[2*n+1].w_val),
                                               SIGNED_CMP != 0, TIE_HIGH != 0));
                assign w_val = w_take_hi ? g_lvl[l+1].g_node[2*n+1].w_val
                                         : g_lvl[l+1].g_node[2*n].w_val;
                assign w_idx = w_take_hi ? g_lvl[l+1].g_node[2*n+1].w_idx
                                         : g_lvl[l+1].g_node[2*n].w_idx;
                assign w_vld = g_lvl[l+1].g_node[2*n].w_vld ||
                               g_lvl[l+1].g_node[2*n+1].w_vld;
            end
        end
    end

    assign o_max_val = g_lvl[0].g_node[0].w_val;
    assign o_max_idx = g_lvl[0].g_node[0].w_idx;

endmodule
`default_nettype wire

// File: rtl/argmax_row_engine.sv
`default_nettype none
// ============================================================================
// Module : argmax_row_engine
// Brief  : scans NUM_ROWS rows through a latency-configurable read port and
//          stores the argmax column and max value of each row
// Rev    : 1.0
// ============================================================================
module argmax_row_engine
    import argmax_pkg::*;
#(
    parameter int NUM_ROWS     = 6,
    parameter int NUM_COLS     = 3,
    parameter int DATA_W       = 16,
    parameter int SIGNED_CMP   = 0,
    parameter int TIE_HIGH     = 0,
    parameter int READ_LATENCY = 1,
    localparam int ROW_W       = clog2_min1(NUM_ROWS),
    localparam int IDX_W       = clog2_min1(NUM_COLS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    output logic                       o_rd_en,
    output logic [ROW_W-1:0]           o_rd_row,
    input  logic [NUM_COLS*DATA_W-1:0] i_rd_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_result_valid,
    output logic [NUM_ROWS*IDX_W-1:0]  o_result_idx,
    output logic [NUM_ROWS*DATA_W-1:0] o_result_val
);

    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(NUM_ROWS - 1);

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [1:0]        r_lat;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic              r_result_valid;
    logic [IDX_W-1:0]  r_res_idx [NUM_ROWS];
    logic [DATA_W-1:0] r_res_val [NUM_ROWS];

    logic [IDX_W-1:0]  w_max_idx;
    logic [DATA_W-1:0] w_max_val;
    logic              w_capture;

    argmax_cmp_tree #(
        .NUM_COLS   (NUM_COLS),
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP),
        .TIE_HIGH   (TIE_HIGH)
    ) u_cmp_tree (
        .i_vec     (i_rd_data),
        .o_max_idx (w_max_idx),
        .o_max_val (w_max_val)
    );

    // With a combinational read port the FETCH cycle doubles as the capture cycle.
    assign w_capture = (r_state == ST_CAPTURE) ||
                       ((READ_LATENCY == 0) && (r_state == ST_FETCH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_row          <= '0;
            r_lat          <= '0;
            r_rd_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                r_res_idx[r] <= '0;
                r_res_val[r] <= '0;
            end
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state        <= ST_FETCH;
                        r_row          <= '0;
                        r_rd_en        <= 1'b1;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (READ_LATENCY == 1) begin
                        r_state <= ST_CAPTURE;
                    end else if (READ_LATENCY > 1) begin
                        r_state <= ST_WAIT;
                        r_lat   <= 2'(READ_LATENCY - 2);
                    end
                end
                ST_WAIT: begin
                    if (r_lat == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                ST_CAPTURE: begin
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Shared by CAPTURE and, at zero latency, FETCH; overrides the case above.
            if (w_capture) begin
                r_res_idx[r_row] <= w_max_idx;
                r_res_val[r_row] <= w_max_val;
                if (r_row == c_last_row) begin
                    r_state        <= ST_DONE;
                    r_row          <= '0;
                    r_done         <= 1'b1;
                    r_result_valid <= 1'b1;
                end else begin
                    r_state <= ST_FETCH;
                    r_row   <= r_row + ROW_W'(1);
                    r_rd_en <= 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_pack
        assign o_result_idx[r*IDX_W +: IDX_W]   = r_res_idx[r];
        assign o_result_val[r*DATA_W +: DATA_W] = r_res_val[r];
    end

    assign o_rd_en        = r_rd_en;
    assign o_rd_row       = r_row;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_argmax_row_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_argmax_row_engine
// Brief  : directed self-checking bench over six engine configurations
// Rev    : 1.0
// ============================================================================
module tb_argmax_row_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic start [6];
    logic rd_en [6];
    logic busy  [6];
    logic done  [6];
    logic rv    [6];
    logic [2:0] rr0, rr1, rr4, rr5;
    logic       rr2, rr3;

    logic [47:0] m3 [6];
    logic [47:0] m1;
    logic [79:0] m5a [6];
    logic [79:0] m5b [6];
    logic [47:0] rd0, rd1, rd2, rd3;
    logic [79:0] rd4, rd5;

    logic [11:0] idx0, idx1;
    logic [95:0] val0, val1, val4, val5;
    logic [1:0]  idx2, idx3;
    logic [15:0] val2, val3;
    logic [17:0] idx4, idx5;

    int exp_idx [3][6];
    int exp_val [3][6];

    localparam logic [47:0] JUNK3 = {3{16'hA5A5}};
    localparam logic [79:0] JUNK5 = {5{16'h5A5A}};

    // Read-port models: data appears exactly READ_LATENCY cycles after rd_en, junk otherwise.
    logic v0, v1, v2, v3;
    logic [47:0] d0, d1, d2, d3;
    logic [2:0]  v5;
    logic [79:0] d5 [3];
    always @(posedge clk) begin
        v0 <= rd_en[0]; d0 <= m3[rr0];
        v1 <= rd_en[1]; d1 <= m3[rr1];
        v2 <= rd_en[2]; d2 <= m1;
        v3 <= rd_en[3]; d3 <= m1;
        v5 <= {v5[1:0], rd_en[5]};
        d5[0] <= m5b[rr5];
        d5[1] <= d5[0];
        d5[2] <= d5[1];
    end
    assign rd0 = v0 ? d0 : JUNK3;
    assign rd1 = v1 ? d1 : JUNK3;
    assign rd2 = v2 ? d2 : JUNK3;
    assign rd3 = v3 ? d3 : JUNK3;
    assign rd4 = rd_en[4] ? m5a[rr4] : JUNK5;
    assign rd5 = v5[2] ? d5[2] : JUNK5;

    argmax_row_engine #(.NUM_ROWS(6), .NUM_COLS(3), .DATA_W(16), .SIGNED_CMP(0), .TIE_HIGH(0), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .i_start(start[0]), .o_rd_en(rd_en[0]), .o_rd_row(rr0), .i_rd_data(rd0),
        .o_busy(busy[0]), .o_done(done[0]), .o_result_valid(rv[0]), .o_result_idx(idx0), .o_result_val(val0));
    argmax_row_engine #(.NUM_ROWS(6), .NUM_COLS(3), .DATA_W(16), .SIGNED_CMP(0), .TIE_HIGH(1), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_start(start[1]), .o_rd_en(rd_en[1]), .o_rd_row(rr1), .i_rd_data(rd1),
        .o_busy(busy[1]), .o_done(done[1]), .o_result_valid(rv[1]), .o_result_idx(idx1), .o_result_val(val1));
    argmax_row_engine #(.NUM_ROWS(1), .NUM_COLS(3), .DATA_W(16), .SIGNED_CMP(1), .TIE_HIGH(0), .READ_LATENCY(1)) u_dut2 (
        .clk(clk), .reset(reset), .i_start(start[2]), .o_rd_en(rd_en[2]), .o_rd_row(rr2), .i_rd_data(rd2),
        .o_busy(busy[2]), .o_done(done[2]), .o_result_valid(rv[2]), .o_result_idx(idx2), .o_result_val(val2));
    argmax_row_engine #(.NUM_ROWS(1), .NUM_COLS(3), .DATA_W(16), .SIGNED_CMP(0), .TIE_HIGH(0), .READ_LATENCY(1)) u_dut3 (
        .clk(clk), .reset(reset), .i_start(start[3]), .o_rd_en(rd_en[3]), .o_rd_row(rr3), .i_rd_data(rd3),
        .o_busy(busy[3]), .o_done(done[3]), .o_result_valid(rv[3]), .o_result_idx(idx3), .o_result_val(val3));
    argmax_row_engine #(.NUM_ROWS(6), .NUM_COLS(5), .DATA_W(16), .SIGNED_CMP(0), .TIE_HIGH(0), .READ_LATENCY(0)) u_dut4 (
        .clk(clk), .reset(reset), .i_start(start[4]), .o_rd_en(rd_en[4]), .o_rd_row(rr4), .i_rd_data(rd4),
        .o_busy(busy[4]), .o_done(done[4]), .o_result_valid(rv[4]), .o_result_idx(idx4), .o_result_val(val4));
    argmax_row_engine #(.NUM_ROWS(6), .NUM_COLS(5), .DATA_W(16), .SIGNED_CMP(1), .TIE_HIGH(1), .READ_LATENCY(3)) u_dut5 (
        .clk(clk), .reset(reset), .i_start(start[5]), .o_rd_en(rd_en[5]), .o_rd_row(rr5), .i_rd_data(rd5),
        .o_busy(busy[5]), .o_done(done[5]), .o_result_valid(rv[5]), .o_result_idx(idx5), .o_result_val(val5));

    function automatic logic [2:0] cur_row(input int id);
        case (id)
            0:       return rr0;
            1:       return rr1;
            2:       return {2'b00, rr2};
            3:       return {2'b00, rr3};
            4:       return rr4;
            default: return rr5;
        endcase
    endfunction

    function automatic logic [15:0] get_idx(input int id, input int r);
        case (id)
            0:       return 16'(idx0[r*2 +: 2]);
            1:       return 16'(idx1[r*2 +: 2]);
            2:       return 16'(idx2);
            3:       return 16'(idx3);
            4:       return 16'(idx4[r*3 +: 3]);
            default: return 16'(idx5[r*3 +: 3]);
        endcase
    endfunction

    function automatic logic [15:0] get_val(input int id, input int r);
        case (id)
            0:       return val0[r*16 +: 16];
            1:       return val1[r*16 +: 16];
            2:       return val2;
            3:       return val3;
            4:       return val4[r*16 +: 16];
            default: return val5[r*16 +: 16];
        endcase
    endfunction

    function automatic logic [47:0] pk3(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    // Linear-scan reference for the five-column configurations.
    function automatic void ref_argmax(input logic [79:0] row, input bit sg, input bit th,
                                       output int bi, output logic [15:0] bv);
        logic [15:0] v;
        bv = row[15:0];
        bi = 0;
        for (int c = 1; c < 5; c++) begin
            v = row[c*16 +: 16];
            if ((sg ? ($signed(v) > $signed(bv)) : (v > bv)) || (th && (v == bv))) begin
                bi = c;
                bv = v;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts engine id, optionally pulses start again at busy cycle poke, and checks timing.
    task automatic run_scan(input int id, input int rows, input int exp_cycle, input int poke);
        int   n;
        int   pulses;
        int   got;
        logic seq_ok;
        @(negedge clk);
        start[id] = 1'b1;
        @(posedge clk);
        #1 start[id] = 1'b0;
        n = 1; pulses = 0; got = 0; seq_ok = 1'b1;
        while (n <= 200 && got == 0) begin
            @(negedge clk);
            if (n == 1) chk($sformatf("rv_cleared_u%0d", id), rv[id], 1'b0);
            if (rd_en[id]) begin
                if (cur_row(id) != pulses[2:0]) seq_ok = 1'b0;
                pulses++;
            end
            if (done[id]) begin
                got = n;
            end else begin
                start[id] = (n == poke);
                @(posedge clk);
                #1 start[id] = 1'b0;
                n++;
            end
        end
        chk($sformatf("done_cycle_u%0d", id), got, exp_cycle);
        chk($sformatf("rd_en_cycles_u%0d", id), pulses, rows);
        chk($sformatf("rd_row_seq_u%0d", id), seq_ok, 1'b1);
        @(negedge clk);
        chk($sformatf("done_pulse_u%0d", id), done[id], 1'b0);
        chk($sformatf("idle_busy_u%0d", id), busy[id], 1'b0);
        chk($sformatf("result_valid_u%0d", id), rv[id], 1'b1);
    endtask

    task automatic check_set(input int id, input int set);
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("idx_u%0d_r%0d", id, r), get_idx(id, r), exp_idx[set][r]);
            chk($sformatf("val_u%0d_r%0d", id, r), get_val(id, r), exp_val[set][r]);
        end
    endtask

    task automatic check_random(input int id, input bit sg, input bit th);
        int          bi;
        logic [15:0] bv;
        for (int r = 0; r < 6; r++) begin
            ref_argmax((id == 4) ? m5a[r] : m5b[r], sg, th, bi, bv);
            chk($sformatf("idx_u%0d_r%0d", id, r), get_idx(id, r), bi);
            chk($sformatf("val_u%0d_r%0d", id, r), get_val(id, r), bv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   found;
        logic saw_done;

        reset = 1'b1;
        for (int i = 0; i < 6; i++) start[i] = 1'b0;
        exp_idx = '{'{1, 2, 0, 0, 0, 2}, '{1, 2, 1, 2, 2, 2}, '{2, 0, 1, 0, 1, 2}};
        exp_val = '{'{9, 8, 4, 0, 7, 3}, '{9, 8, 4, 0, 7, 3}, '{9, 8, 7, 6, 9, 2}};
        m3[0] = pk3(5, 9, 2); m3[1] = pk3(3, 1, 8); m3[2] = pk3(4, 4, 1);
        m3[3] = pk3(0, 0, 0); m3[4] = pk3(7, 6, 7); m3[5] = pk3(1, 2, 3);
        m1 = {16'h0000, 16'h0002, 16'hFFFF};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
                m5a[r][c*16 +: 16] = 16'($urandom_range(0, 7));
                m5b[r][c*16 +: 16] = 16'($urandom_range(0, 15)) - 16'd8;
            end
        end
        m5a[0] = {5{16'd3}};
        m5b[0] = {5{16'hFFFE}};
        m5b[1] = {16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_result_valid", rv[0], 1'b0);
        chk("rst_rd_en", rd_en[0], 1'b0);
        chk("rst_rd_row", rr0, 3'd0);
        chk("rst_result_idx", idx0, 12'd0);
        chk("rst_result_val", val0, 96'd0);
        reset = 1'b0;

        // Lowest-index and highest-index tie rules over the same matrix.
        run_scan(0, 6, 13, 0);
        check_set(0, 0);
        run_scan(1, 6, 13, 0);
        check_set(1, 1);

        // Single-row engines, signed versus unsigned interpretation of 16'hFFFF.
        run_scan(2, 1, 3, 0);
        chk("signed_idx", get_idx(2, 0), 16'd1);
        chk("signed_val", get_val(2, 0), 16'd2);
        run_scan(3, 1, 3, 0);
        chk("unsigned_idx", get_idx(3, 0), 16'd0);
        chk("unsigned_val", get_val(3, 0), 16'hFFFF);

        // Zero and three-cycle read latency with five columns.
        run_scan(4, 6, 7, 0);
        check_random(4, 1'b0, 1'b0);
        run_scan(5, 6, 25, 0);
        check_random(5, 1'b1, 1'b1);

        // Restart with new data and a stray start while busy.
        m3[0] = pk3(3, 3, 9); m3[1] = pk3(8, 1, 1); m3[2] = pk3(2, 7, 7);
        m3[3] = pk3(6, 5, 4); m3[4] = pk3(0, 9, 0); m3[5] = pk3(1, 1, 2);
        run_scan(0, 6, 13, 3);
        check_set(0, 2);

        // Asynchronous reset in the middle of row 3.
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clk);
            if (rd_en[0] && rr0 == 3'd3) found = 1;
        end
        chk("reset_reach_row3", found, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_result_valid", rv[0], 1'b0);
        chk("midrst_idx", idx0, 12'd0);
        chk("midrst_val", val0, 96'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 1'b0);
        reset = 1'b0;
        run_scan(0, 6, 13, 0);
        check_set(0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
